flap_input: RTL

- Input conditioner for the flap button. Sits directly upstream of the game controller and drives its `up` input.
- Synchronises the raw button into the clk domain and debounces it.
- Emits a single-cycle `up_pulse` per validated press, a clean `up_level`, and a release pulse.
- Lets the top level suppress flap pulses (e.g. while `fail` is high) without losing debounce state.

---
 rtl/flap_input.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/flap_input.sv
// flap_input: synchronises and debounces the flap button. It produces a clean
// level, a one-cycle press pulse that enable can gate, and a one-cycle release
// pulse.
// Optional feature macro: FLAP_INPUT_AUTO_REPEAT_EN. When it is defined, holding
// the button re-fires up_pulse every REPEAT_CYCLES cycles.
module flap_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 25000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic up_raw,
  input  logic enable,
  output logic up_level,
  output logic up_pulse,
  output logic up_release
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Reject configurations the counters cannot represent
  if (DEBOUNCE_CYCLES == 0 || REPEAT_CYCLES == 0 ||
      64'(DEBOUNCE_CYCLES) >= (64'(1) << CNT_W) ||
      64'(REPEAT_CYCLES) >= (64'(1) << CNT_W)) begin : g_param_err
    $error("flap_input: invalid DEBOUNCE_CYCLES/REPEAT_CYCLES/CNT_W");
  end

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             release_q, release_d;
`ifdef FLAP_INPUT_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rpt_q, rpt_d;
`endif

  // Two-flop synchroniser input for the asynchronous button pin
  always_comb begin
    s1_d = up_raw;
    s2_d = s1_q;
  end

  // Debounce FSM: next state, counters and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    pulse_d   = 1'b0;
    release_d = 1'b0;
`ifdef FLAP_INPUT_AUTO_REPEAT_EN
    rpt_d     = rpt_q;
`endif
    case (state_q)
      IDLE_LO: begin
`ifdef FLAP_INPUT_AUTO_REPEAT_EN
        rpt_d = '0;
`endif
        if (s2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HI: begin
        if (!s2_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LIMIT) begin
          state_d = IDLE_HI;
          level_d = 1'b1;
          pulse_d = enable;
          cnt_d   = '0;
`ifdef FLAP_INPUT_AUTO_REPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
`ifdef FLAP_INPUT_AUTO_REPEAT_EN
        if (rpt_q == RPT_LAST) begin
          rpt_d   = '0;
          pulse_d = enable;
        end else begin
          rpt_d = rpt_q + CNT_ONE;
        end
`endif
        if (!s2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LO: begin
        // A bounce back to high keeps rpt, so the repeat cadence continues
        if (s2_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LIMIT) begin
          state_d   = IDLE_LO;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, synchroniser and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef FLAP_INPUT_AUTO_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      release_q <= release_d;
`ifdef FLAP_INPUT_AUTO_REPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign up_level   = level_q;
  assign up_pulse   = pulse_q;
  assign up_release = release_q;

endmodule
